// File: rtl/ahb_apb_pkg.sv
// Shared types and address map for the AHB-to-APB bridge.
// Holds the AHB transfer-type and bridge-state enums, the three APB slave
// regions, and the address-to-select decode used by the bridge.
package ahb_apb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_SLAVES = 3;

  // AHB HTRANS encoding
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Bridge control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WWAIT  = 2'b01,
    ST_SETUP  = 2'b10,
    ST_ENABLE = 2'b11
  } bridge_state_e;

  // APB slave regions, 64 MB each, contiguous from 0x8000_0000
  localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [NUM_SLAVES-1:0] PSEL_NONE = '0;

  // One-hot slave select for an address; all-zero when no region claims it.
  function automatic logic [NUM_SLAVES-1:0] decode_psel(input logic [31:0] addr);
    logic [NUM_SLAVES-1:0] sel;
    sel = PSEL_NONE;
    if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
      sel = 3'b001;
    end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
      sel = 3'b010;
    end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
      sel = 3'b100;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// AHB address-phase qualifier: flags a transfer the bridge must act on and
// gives its one-hot APB slave select. Purely combinational, zero latency.
// Ports: hreadyin_i/htrans_i/haddr_i in; valid_o, psel_o out.
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  hreadyin_i,
  input  logic [1:0]            htrans_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  output logic                  valid_o,
  output logic [NUM_SLAVES-1:0] psel_o
);

  logic [31:0]  addr32;
  logic         active_trans;
  htrans_e      trans;

  // The region map is defined on a 32-bit address; resize whatever width we get.
  assign addr32 = 32'(haddr_i);
  assign trans  = htrans_e'(htrans_i);

  // Only NONSEQ/SEQ carry a real transfer; IDLE and BUSY are ignored.
  assign active_trans = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);

  assign psel_o  = decode_psel(addr32);
  assign valid_o = hreadyin_i && active_trans && (psel_o != PSEL_NONE);

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: runs each valid AHB transfer as an APB SETUP/ENABLE pair
// to one of three slaves. Reads take one AHB wait state, writes two (an extra
// cycle to collect Hwdata). A new address accepted in ENABLE chains directly
// into the next APB transfer. Hresp is always OKAY.
// Ports: AHB side Haddr/Htrans/Hwrite/Hwdata/Hreadyin in, Hrdata/Hreadyout/Hresp
// out; APB side Paddr/Pwdata/Pwrite/Penable/Pselx out, Prdata in.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  Hwrite,
  input  logic                  Hreadyin,
  input  logic [1:0]            Htrans,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [DATA_WIDTH-1:0] Prdata,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic [1:0]            Hresp,
  output logic                  Hreadyout,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic [DATA_WIDTH-1:0] Pwdata,
  output logic [ADDR_WIDTH-1:0] Paddr
);

  bridge_state_e         state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  pwrite_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] pselx_q;
  logic                  penable_q;
  logic                  hreadyout_q;

  logic                  xfer_vld;
  logic [NUM_SLAVES-1:0] dec_sel;

  ahb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .hreadyin_i (Hreadyin),
    .htrans_i   (Htrans),
    .haddr_i    (Haddr),
    .valid_o    (xfer_vld),
    .psel_o     (dec_sel)
  );

  // Control FSM. Outputs are registered together with the state, so each
  // branch loads the output values belonging to the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      sel_q       <= PSEL_NONE;
      pselx_q     <= PSEL_NONE;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
    end else begin
      case (state_q)
        // IDLE and ENABLE both present Hreadyout=1, so both may accept a new
        // address phase; ENABLE doing so is what removes the idle gap between
        // back-to-back APB transfers.
        ST_IDLE, ST_ENABLE: begin
          if (xfer_vld) begin
            paddr_q     <= Haddr;
            pwrite_q    <= Hwrite;
            sel_q       <= dec_sel;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b0;
            if (Hwrite) begin
              // Write data only arrives next cycle; hold APB quiet until then.
              state_q <= ST_WWAIT;
              pselx_q <= PSEL_NONE;
            end else begin
              state_q <= ST_SETUP;
              pselx_q <= dec_sel;
            end
          end else begin
            state_q     <= ST_IDLE;
            pselx_q     <= PSEL_NONE;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
          end
        end

        ST_WWAIT: begin
          pwdata_q    <= Hwdata;
          state_q     <= ST_SETUP;
          pselx_q     <= sel_q;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b0;
        end

        ST_SETUP: begin
          state_q     <= ST_ENABLE;
          pselx_q     <= sel_q;
          penable_q   <= 1'b1;
          hreadyout_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          pselx_q     <= PSEL_NONE;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b1;
        end
      endcase
    end
  end

  // Read data passes straight through from the slave during the ENABLE of a
  // read, so it is valid in the same cycle Hreadyout completes the transfer.
  assign Hrdata = (state_q == ST_ENABLE && !pwrite_q) ? Prdata : '0;

  assign Hresp     = 2'b00;
  assign Hreadyout = hreadyout_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Pselx     = pselx_q;
  assign Pwdata    = pwdata_q;
  assign Paddr     = paddr_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed scenarios followed by
// randomized transfers, each checked cycle by cycle against a transfer-level
// model of the expected AHB/APB behaviour.
module tb_ahb_apb_bridge;

  logic        clk;
  logic        resetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Hwdata;
  logic [31:0] Haddr;
  logic [31:0] Prdata;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic        Penable;
  logic        Pwrite;
  logic [2:0]  Pselx;
  logic [31:0] Pwdata;
  logic [31:0] Paddr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model of the APB-side holding registers
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pwrite;

  ahb_apb_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Hwdata    (Hwdata),
    .Haddr     (Haddr),
    .Prdata    (Prdata),
    .Hrdata    (Hrdata),
    .Hresp     (Hresp),
    .Hreadyout (Hreadyout),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Pselx     (Pselx),
    .Pwdata    (Pwdata),
    .Paddr     (Paddr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Three consecutive 64 MB windows starting at 0x8000_0000, one slave each.
  function automatic logic [2:0] m_sel(input logic [31:0] a);
    longint unsigned off;
    if (a < 32'h8000_0000) return 3'b000;
    off = longint'(a) - longint'(32'h8000_0000);
    if (off >= 3 * 64'h0400_0000) return 3'b000;
    return 3'b001 << (off / 64'h0400_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [2:0] sel, input logic pen,
                           input logic rdy, input logic [31:0] hr);
    chk({tag, ".psel"},   32'(Pselx),     32'(sel));
    chk({tag, ".penable"}, 32'(Penable),  32'(pen));
    chk({tag, ".hready"}, 32'(Hreadyout), 32'(rdy));
    chk({tag, ".hrdata"}, Hrdata,         hr);
    chk({tag, ".hresp"},  32'(Hresp),     32'd0);
    chk({tag, ".paddr"},  Paddr,          m_paddr);
    chk({tag, ".pwdata"}, Pwdata,         m_pwdata);
    chk({tag, ".pwrite"}, 32'(Pwrite),    32'(m_pwrite));
  endtask

  // One AHB transfer issued from IDLE, followed through to completion.
  // During ENABLE a valid-looking address is offered with Hreadyin=0, which
  // must not be sampled, so the bridge returns to IDLE afterwards.
  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [1:0] trans, input logic rdy,
                         input logic [31:0] wdata, input logic [31:0] rdata);
    logic [2:0] s;
    logic       v;
    s = m_sel(addr);
    v = rdy && trans[1] && (s != 3'b000);
    @(posedge clk); #1;
    Haddr = addr; Hwrite = wr; Htrans = trans; Hreadyin = rdy; Prdata = rdata;
    @(negedge clk);
    check_bus({tag, ".c0"}, 3'b000, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    if (v) begin
      m_paddr  = addr;
      m_pwrite = wr;
    end
    Htrans = 2'b00; Hreadyin = 1'b1; Hwdata = wdata; Haddr = $urandom;
    @(negedge clk);
    if (!v) begin
      check_bus({tag, ".ign"}, 3'b000, 1'b0, 1'b1, 32'd0);
      return;
    end
    if (wr) begin
      check_bus({tag, ".wwait"}, 3'b000, 1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      m_pwdata = wdata;
      Hwdata   = $urandom;
      @(negedge clk);
    end
    check_bus({tag, ".setup"}, s, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    Htrans = 2'b10; Hreadyin = 1'b0; Haddr = 32'h8000_0000;
    @(negedge clk);
    check_bus({tag, ".enable"}, s, 1'b1, 1'b1, wr ? 32'd0 : rdata);
    @(posedge clk); #1;
    Htrans = 2'b00; Hreadyin = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    int          pick;

    resetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
    Hwdata = '0; Haddr = '0; Prdata = 32'hA5A5_5A5A;
    m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;

    // Reset state
    @(negedge clk);
    check_bus("reset", 3'b000, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single write to slave 0
    do_xfer("wr0", 32'h8000_0010, 1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);

    // Single read from slave 1
    do_xfer("rd1", 32'h8400_0004, 1'b0, 2'b10, 1'b1, 32'h0, 32'h1234_5678);

    // Back-to-back reads to slave 2, second address presented in ENABLE
    @(posedge clk); #1;
    Haddr = 32'h8800_0000; Hwrite = 1'b0; Htrans = 2'b10; Hreadyin = 1'b1;
    Prdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    m_paddr = 32'h8800_0000; m_pwrite = 1'b0;
    Htrans = 2'b00;
    @(negedge clk);
    check_bus("b2b.setup1", 3'b100, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    Haddr = 32'h8800_0004; Htrans = 2'b11;
    @(negedge clk);
    check_bus("b2b.enable1", 3'b100, 1'b1, 1'b1, 32'hCAFE_0001);
    @(posedge clk); #1;
    m_paddr = 32'h8800_0004;
    Htrans = 2'b00; Prdata = 32'hCAFE_0002;
    @(negedge clk);
    check_bus("b2b.setup2", 3'b100, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_bus("b2b.enable2", 3'b100, 1'b1, 1'b1, 32'hCAFE_0002);
    @(posedge clk); #1;

    // Ignored transfers: BUSY in range, NONSEQ out of range
    do_xfer("busy", 32'h8000_0000, 1'b0, 2'b01, 1'b1, 32'h0, 32'h1111_1111);
    do_xfer("oor",  32'h9000_0000, 1'b1, 2'b10, 1'b1, 32'h5555_5555, 32'h2222_2222);

    // Hreadyin low suppresses sampling; same transfer with Hreadyin high runs
    do_xfer("nordy", 32'h8400_0100, 1'b0, 2'b10, 1'b0, 32'h0, 32'h3333_3333);
    do_xfer("rdy",   32'h8400_0100, 1'b0, 2'b10, 1'b1, 32'h0, 32'h3333_3333);

    // Reset asserted while a write sits in SETUP
    @(posedge clk); #1;
    Haddr = 32'h8800_0040; Hwrite = 1'b1; Htrans = 2'b10; Hreadyin = 1'b1;
    @(posedge clk); #1;
    m_paddr = 32'h8800_0040; m_pwrite = 1'b1;
    Htrans = 2'b00; Hwdata = 32'h7777_8888;
    @(posedge clk); #1;
    m_pwdata = 32'h7777_8888;
    @(negedge clk);
    check_bus("rst.setup", 3'b100, 1'b0, 1'b0, 32'd0);
    #1 resetn = 1'b0;
    m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
    #1;
    check_bus("rst.async", 3'b000, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    check_bus("rst.hold", 3'b000, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Randomized transfers across regions, boundaries and stray addresses
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0, 1, 2: a = 32'h8000_0000 + pick * 32'h0400_0000 + ($urandom & 32'h03FF_FFFC);
        3:       a = $urandom;
        4: begin
          case ($urandom_range(0, 3))
            0:       a = 32'h7FFF_FFFC;
            1:       a = 32'h8BFF_FFFC;
            2:       a = 32'h8C00_0000;
            default: a = 32'h87FF_FFFF;
          endcase
        end
        default: a = 32'h8000_0000 + ($urandom_range(0, 2) * 32'h0400_0000);
      endcase
      do_xfer($sformatf("rnd%0d", i), a, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'($urandom_range(2, 3)),
              ($urandom_range(0, 7) != 0), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
